ring_clk_div: RTL
=================

Name: ring_clk_div

Overview:
Parametrised ring-counter clock divider with a runtime-programmable ring length and mode.
- One-hot mode gives a 1-of-L pulse; Johnson (twisted-ring) mode gives 50% duty at period 2L.
- Configuration is accepted over a valid/ready handshake and applied only at a wrap boundary, so the output never glitches.
- Sits between the system clock and GPIO or strobe consumers as a general clock-enable / divided-clock source.

Parameters:
- N_MAX, 8: physical ring width; maximum programmable length L.
- LEN_W, 4: width of the length field; must satisfy 2^LEN_W > N_MAX.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; ring holds while low.
- cfg_len  in  LEN_W  requested ring length L.
- cfg_mode  in  1  0 = one-hot, 1 = Johnson.
- cfg_vld  in  1  config request valid.
- cfg_rdy  out  1  config slot empty; request accepted when cfg_vld & cfg_rdy.
- ring_o  out  N_MAX  ring state; bits [N_MAX-1:L] always 0.
- div_o  out  1  divided output: ring_o[0] in one-hot mode, ring_o[L-1] in Johnson mode.
- tick_o  out  1  one-cycle pulse = en & wrap.
- len_o  out  LEN_W  active (clamped) length.
- mode_o  out  1  active mode.
- err_o  out  1  sticky illegal-state flag (optional feature only).

Behaviour:
- Reset (sys_rst=1 at a clock edge, overrides everything):
  - L = N_MAX, mode = one-hot, ring_o = 1, pending slot cleared.
  - Outputs: cfg_rdy = 1, div_o = 1, tick_o = 0, err_o = 0.
- Start pattern: one-hot 0…01; Johnson 0…00.
- Last state (both modes): only bit L-1 set. wrap = (ring_o == last state).
- Advance when en=1:
  - One-hot: ring[L-1:0] <= {ring[L-2:0], ring[L-1]}; period L.
  - Johnson: ring[L-1:0] <= {ring[L-2:0], ~ring[L-1]}; period 2L, div_o high L cycles, low L cycles.
- Advance when en=0: ring_o holds and tick_o = 0.
- div_o and tick_o are combinational decodes of registered state; no extra latency.
- Config slot (single entry):
  - On accept, store clamp(cfg_len) and cfg_mode; cfg_rdy drops next cycle.
  - clamp: values <2 become 2; values >N_MAX become N_MAX.
- Apply pending config:
  - If en=1: on the first wrap strictly after the accept cycle. An accept coinciding with a wrap waits for the next wrap.
  - If en=0: on the cycle after accept (ring idle, no glitch concern).
  - On apply: ring_o <= start pattern of the new mode, bits above the new L cleared, len_o/mode_o updated. The slot frees and cfg_rdy=1 next cycle.
- A request presented while cfg_rdy=0 is not accepted; the requester must hold it. The pending entry is never overwritten.
- A pending config is dropped by sys_rst.
- tick_o is asserted in the last-state cycle even if a config is applied at that edge.

Optional Feature:
- Macro RING_SELFCHK_EN.
- Defined:
  - Each cycle, check ring_o for legality. One-hot: exactly one bit set within [L-1:0]. Johnson: at most one i<L-1 with ring[i]!=ring[i+1]. Both modes: no bits set above L-1.
  - On an illegal state: next ring_o = start pattern of the current mode, and err_o set sticky until sys_rst.
  - Self-correction has priority over advance and apply; a pending config stays pending.
- Undefined: no checker logic; err_o tied 0; illegal states propagate.

Decomposition:
- Package ring_div_pkg: MODE_ONEHOT=1'b0, MODE_JOHNSON=1'b1, length-clamp function, start-pattern and last-state functions (parameterised by N_MAX and L).
- Sub-module ring_cfg_slot: one-entry valid/ready holding register (store, pending flag, release on apply).
- Ring, decode and checker stay in the top module.

Test Plan:
- Reset then en=1 (N_MAX=8) -> ring_o 01,02,04,…,80,01; tick_o high each 80 state; div_o high 1 of 8 cycles.
- Accept len=3, mode=1 mid-period -> old period completes, then 000,001,011,111,110,100 repeating; div_o 3 high / 3 low; len_o=3, mode_o=1 from the apply cycle.
- Accept on the exact wrap cycle -> one more full old period before apply; a second request during pending -> cfg_rdy=0, not accepted, first config unchanged.
- cfg_len=0 -> len_o=2 (one-hot period 2); cfg_len=15 -> len_o=8.
- en=0 with ring at 04 -> holds, tick_o=0; accept len=5 -> applied next cycle, ring_o=01.
- sys_rst asserted mid-Johnson with a pending config -> next cycle ring_o=01, len_o=8, mode_o=0, cfg_rdy=1; with RING_SELFCHK_EN, deposit ring_o=0x05 -> next cycle ring_o=01, err_o=1 and it stays 1.

Source files
------------

// File: rtl/ring_div_pkg.sv
// Shared mode encodings and ring-pattern helpers for the ring clock divider.
// Helpers return 32-bit values; callers cast down to their ring width.
package ring_div_pkg;

  localparam logic MODE_ONEHOT  = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Requested length limited to the legal range [2, n_max].
  function automatic int clamp_len(input int len, input int n_max);
    if (len < 2) return 2;
    if (len > n_max) return n_max;
    return len;
  endfunction

  // First state after apply or self-correction.
  function automatic logic [31:0] start_pattern(input logic mode);
    return (mode == MODE_ONEHOT) ? 32'd1 : 32'd0;
  endfunction

  // Final state of a period in both modes: only bit len-1 set.
  function automatic logic [31:0] last_state(input int len);
    return 32'd1 << (len - 1);
  endfunction

  // Bits [len-1:0] set.
  function automatic logic [31:0] len_mask(input int len);
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/ring_clk_div_if.sv
// Configuration request channel for ring_clk_div (valid/ready).
interface ring_clk_div_if #(
  parameter int LEN_W = 4
);
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_mode;
  logic             cfg_vld;
  logic             cfg_rdy;

  modport master (output cfg_len, output cfg_mode, output cfg_vld, input cfg_rdy);
  modport slave  (input cfg_len, input cfg_mode, input cfg_vld, output cfg_rdy);
endinterface

// File: rtl/ring_cfg_slot.sv
// Single-entry holding register for a pending ring configuration.
// Accepts while empty, holds until the ring applies it; never overwritten.
module ring_cfg_slot #(
  parameter int LEN_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_vld,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_mode,
  input  logic             i_apply,
  output logic             o_rdy,
  output logic             o_pend,
  output logic [LEN_W-1:0] o_len,
  output logic             o_mode
);

  logic             r_pend;
  logic [LEN_W-1:0] r_len;
  logic             r_mode;

  // Capture on accept, release when the ring consumes the entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pend <= 1'b0;
      r_len  <= '0;
      r_mode <= 1'b0;
    end else if (i_vld && !r_pend) begin
      r_pend <= 1'b1;
      r_len  <= i_len;
      r_mode <= i_mode;
    end else if (i_apply) begin
      r_pend <= 1'b0;
    end
  end

  assign o_rdy  = ~r_pend;
  assign o_pend = r_pend;
  assign o_len  = r_len;
  assign o_mode = r_mode;

endmodule

// File: rtl/ring_clk_div.sv
// Ring-counter clock divider, one-hot (period L) or Johnson (period 2L).
// New configuration takes effect only at a wrap while running, so div_o
// never glitches. Optional macro RING_SELFCHK_EN adds an illegal-state
// checker that resets the ring to its start pattern and sets sticky err_o.
module ring_clk_div
  import ring_div_pkg::*;
#(
  parameter int N_MAX = 8,
  parameter int LEN_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  ring_clk_div_if.slave    cfg_if,
  output logic [N_MAX-1:0] ring_o,
  output logic             div_o,
  output logic             tick_o,
  output logic [LEN_W-1:0] len_o,
  output logic             mode_o,
  output logic             err_o
);

  logic [N_MAX-1:0] r_ring;
  logic [LEN_W-1:0] r_len;
  logic             r_mode;

  logic [N_MAX-1:0] w_mask;
  logic [N_MAX-1:0] w_last;
  logic [N_MAX-1:0] w_ring_nxt;
  logic [LEN_W-1:0] w_len_clamped;
  logic [LEN_W-1:0] w_slot_len;
  logic             w_slot_mode;
  logic             w_pend;
  logic             w_wrap;
  logic             w_msb;
  logic             w_apply;
  logic             w_illegal;

  assign w_mask        = N_MAX'(len_mask(int'(r_len)));
  assign w_last        = N_MAX'(last_state(int'(r_len)));
  assign w_wrap        = (r_ring == w_last);
  assign w_msb         = |(r_ring & w_last);
  assign w_len_clamped = LEN_W'(clamp_len(int'(cfg_if.cfg_len), N_MAX));

  // While idle there is no glitch risk, so a pending entry applies at once.
  assign w_apply = w_pend & (en ? w_wrap : 1'b1) & ~w_illegal;

  ring_cfg_slot #(.LEN_W(LEN_W)) u_slot (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_vld   (cfg_if.cfg_vld),
    .i_len   (w_len_clamped),
    .i_mode  (cfg_if.cfg_mode),
    .i_apply (w_apply),
    .o_rdy   (cfg_if.cfg_rdy),
    .o_pend  (w_pend),
    .o_len   (w_slot_len),
    .o_mode  (w_slot_mode)
  );

  // Rotate within [L-1:0]; Johnson feeds back the inverted top bit.
  always_comb begin
    w_ring_nxt    = '0;
    w_ring_nxt[0] = (r_mode == MODE_JOHNSON) ? ~w_msb : w_msb;
    for (int i = 1; i < N_MAX; i++) begin
      if (i < int'(r_len)) w_ring_nxt[i] = r_ring[i-1];
    end
  end

`ifdef RING_SELFCHK_EN
  int   w_ones;
  int   w_edges;
  logic r_err;

  // Legality: one-hot has exactly one bit in range; Johnson has at most one
  // 0/1 boundary in range; nothing may be set above L-1.
  always_comb begin
    w_ones  = 0;
    w_edges = 0;
    for (int i = 0; i < N_MAX; i++) begin
      if (r_ring[i] && w_mask[i]) w_ones = w_ones + 1;
    end
    for (int i = 0; i < N_MAX - 1; i++) begin
      if ((i < int'(r_len) - 1) && (r_ring[i] != r_ring[i+1])) w_edges = w_edges + 1;
    end
    w_illegal = (|(r_ring & ~w_mask)) ||
                ((r_mode == MODE_ONEHOT) ? (w_ones != 1) : (w_edges > 1));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)        r_err <= 1'b0;
    else if (w_illegal) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign w_illegal = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Ring state: reset, then self-correction, then apply, then advance.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ring <= N_MAX'(1);
      r_len  <= LEN_W'(N_MAX);
      r_mode <= MODE_ONEHOT;
    end else if (w_illegal) begin
      r_ring <= N_MAX'(start_pattern(r_mode));
    end else if (w_apply) begin
      r_ring <= N_MAX'(start_pattern(w_slot_mode));
      r_len  <= w_slot_len;
      r_mode <= w_slot_mode;
    end else if (en) begin
      r_ring <= w_ring_nxt;
    end
  end

  assign ring_o = r_ring;
  assign div_o  = (r_mode == MODE_JOHNSON) ? w_msb : r_ring[0];
  assign tick_o = en & w_wrap;
  assign len_o  = r_len;
  assign mode_o = r_mode;

endmodule
